spi_slave_rx: RTL and testbench

- SPI mode-0 slave endpoint for the 40-bit register-write frames our FPGA-side SPI master sends; it is the far end of that link.
- Used as the RF-chip register model in simulation and as the slave port for FPGA-to-FPGA loopback.
- Oversamples spi_sclk/spi_cs_n/spi_mosi on clk, deserialises MSB-first frames, and issues a write strobe per frame.
- Serves read frames by fetching data from a host-side register interface and shifting it out on spi_miso.

---
 rtl/spi_slave_rx.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversamples the SPI pins on clk, deserialises MSB-first {rw, addr, data} frames,
// issues a write strobe per write frame and serves read frames from a host register port.
module spi_slave_rx #(
  parameter int ADDR_BITS   = 7,
  parameter int DATA_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 miso_oe,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 rd_req,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 frame_err,
  output logic [5:0]           bit_count
);

  localparam int FRAME_BITS = 1 + ADDR_BITS + DATA_BITS;
  localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);
  localparam logic [5:0] HDR_CNT   = 6'(ADDR_BITS + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;
  logic [FRAME_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic [5:0]             bit_count_q, bit_count_d;
  logic                   rd_frame_q, rd_frame_d;
  logic                   rd_load_q, rd_load_d;
  logic                   frame_done_q, frame_done_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]   wr_data_q, wr_data_d;
  logic                   rd_req_q, rd_req_d;
  logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic                   frame_err_q, frame_err_d;

  logic                  sclk_s, cs_s, mosi_s;
  logic                  sclk_rise, sclk_fall, cs_fall;
  logic [FRAME_BITS-1:0] rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign rx_next   = {rx_shift_q[FRAME_BITS-2:0], mosi_s};

  always_comb begin
    state_d      = state_q;
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_hist_d  = sclk_s;
    cs_hist_d    = cs_s;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    bit_count_d  = bit_count_q;
    rd_frame_d   = rd_frame_q;
    rd_load_d    = rd_req_q;
    frame_done_d = 1'b0;
    miso_d       = miso_q;
    rd_req_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    frame_err_d  = 1'b0;
    miso_oe_d    = ~cs_s & (state_q != WAIT_IDLE);

    // Host data arrives one clk after rd_req; it lands well before the first miso falling edge.
    if (rd_load_q) begin
      tx_shift_d = rd_data;
    end

    case (state_q)
      WAIT_IDLE: begin
        miso_d = 1'b0;
        if (cs_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          bit_count_d = '0;
          rd_frame_d  = 1'b0;
          tx_shift_d  = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise && bit_count_q < FRAME_CNT) begin
          rx_shift_d  = rx_next;
          bit_count_d = bit_count_q + 6'd1;
          if (bit_count_q == HDR_CNT - 6'd1 && rx_next[ADDR_BITS]) begin
            rd_req_d   = 1'b1;
            rd_addr_d  = rx_next[ADDR_BITS-1:0];
            rd_frame_d = 1'b1;
          end
          if (bit_count_q == FRAME_CNT - 6'd1) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
            miso_d       = 1'b0;
          end
        end else if (sclk_fall && rd_frame_q && bit_count_q >= HDR_CNT && bit_count_q < FRAME_CNT) begin
          miso_d     = tx_shift_q[DATA_BITS-1];
          tx_shift_d = {tx_shift_q[DATA_BITS-2:0], 1'b0};
        end
        // A final edge arriving together with cs release still completes the frame.
        if (cs_s && state_d != DONE) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if (bit_count_d != 6'd0) begin
            frame_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    wr_valid_d = frame_done_q & ~rx_shift_q[FRAME_BITS-1];
    wr_addr_d  = wr_valid_d ? rx_shift_q[FRAME_BITS-2:DATA_BITS] : wr_addr_q;
    wr_data_d  = wr_valid_d ? rx_shift_q[DATA_BITS-1:0] : wr_data_q;
  end

  // cs synchroniser clears to 0 so WAIT_IDLE only leaves on a genuinely high pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_IDLE;
      sclk_sync_q  <= '0;
      cs_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sclk_hist_q  <= 1'b0;
      cs_hist_q    <= 1'b0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      bit_count_q  <= '0;
      rd_frame_q   <= 1'b0;
      rd_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_hist_q  <= sclk_hist_d;
      cs_hist_q    <= cs_hist_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      bit_count_q  <= bit_count_d;
      rd_frame_q   <= rd_frame_d;
      rd_load_q    <= rd_load_d;
      frame_done_q <= frame_done_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign spi_miso  = miso_q;
  assign miso_oe   = miso_oe_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign frame_err = frame_err_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a bit-banged SPI master at clk/10 plus a frame-level reference model.
module tb_spi_slave_rx;
  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, miso_oe, wr_valid, rd_req, frame_err;
  logic [6:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [5:0]  bit_count;

  int checks = 0;
  int errors = 0;

  // Observed-event tallies, gathered at negedge away from the active edge.
  int          wr_cnt = 0, err_cnt = 0, rd_cnt = 0, miso_hi_cnt = 0;
  logic [6:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] host_val = '0;

  spi_slave_rx #(.ADDR_BITS(7), .DATA_BITS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .miso_oe(miso_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_err(frame_err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (wr_valid === 1'b1) begin
        wr_cnt++;
        last_wr_addr = wr_addr;
        last_wr_data = wr_data;
      end
      if (rd_req === 1'b1) begin
        rd_cnt++;
        last_rd_addr = rd_addr;
      end
      if (frame_err === 1'b1) err_cnt++;
      if (spi_miso === 1'b1) miso_hi_cnt++;
    end
  end

  // Host register port: answers one clk after it sees rd_req.
  initial begin
    rd_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rd_req === 1'b1) begin
        @(posedge clk);
        #1 rd_data = host_val;
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side: cs low, nedges mode-0 bits, cs high. Captures miso on rising edges 9..40.
  task automatic shift_frame(input logic [39:0] f, input int nedges, output logic [31:0] cap);
    cap = '0;
    spi_cs_n = 1'b0;
    clk_wait(5);
    for (int i = 1; i <= nedges; i++) begin
      spi_mosi = (i <= 40) ? f[40 - i] : 1'($urandom_range(0, 1));
      clk_wait(5);
      if (i >= 9 && i <= 40) cap = {cap[30:0], spi_miso};
      spi_sclk = 1'b1;
      clk_wait(5);
      spi_sclk = 1'b0;
    end
    clk_wait(5);
    spi_cs_n = 1'b1;
    clk_wait(12);
  endtask

  task automatic test_reset;
    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    clk_wait(3);
    checks++;
    if ({spi_miso, miso_oe, wr_valid, rd_req, frame_err} !== 5'b0 ||
        wr_addr !== 7'h0 || wr_data !== 32'h0 || rd_addr !== 7'h0 || bit_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs: got miso=%b oe=%b wv=%b rr=%b fe=%b wa=%h wd=%h ra=%h bc=%0d, expected all zero",
               spi_miso, miso_oe, wr_valid, rd_req, frame_err, wr_addr, wr_data, rd_addr, bit_count);
    end
    reset = 1'b0;
    clk_wait(5);
  endtask

  task automatic test_idle_toggles;
    logic [31:0] cap;
    int w0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      spi_sclk = 1'b1; clk_wait(5);
      spi_sclk = 1'b0; clk_wait(5);
      checks++;
      if (bit_count !== 6'd0) begin
        errors++;
        $display("FAIL idle_toggle_bitcount: toggle %0d got %0d expected 0", i, bit_count);
      end
    end
    shift_frame({1'b0, 7'h00, 32'h0}, 40, cap);
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_addr !== 7'h00 || last_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL idle_then_write: got %0d writes addr=%h data=%h expected 1 addr=00 data=0",
               wr_cnt - w0, last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_write;
    logic [31:0] cap;
    int w0 = wr_cnt, e0 = err_cnt, m0 = miso_hi_cnt;
    shift_frame({1'b0, 7'h15, 32'hDEADBEEF}, 40, cap);
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++; $display("FAIL write_count: got %0d expected 1", wr_cnt - w0);
    end
    checks++;
    if (last_wr_addr !== 7'h15 || last_wr_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_value: got %h/%h expected 15/deadbeef", last_wr_addr, last_wr_data);
    end
    checks++;
    if (err_cnt - e0 !== 0 || miso_hi_cnt - m0 !== 0) begin
      errors++; $display("FAIL write_side_effects: got err=%0d miso_hi=%0d expected 0/0", err_cnt - e0, miso_hi_cnt - m0);
    end
    checks++;
    if (bit_count !== 6'd40) begin
      errors++; $display("FAIL write_bitcount: got %0d expected 40", bit_count);
    end
  endtask

  task automatic test_read;
    logic [31:0] cap;
    int w0 = wr_cnt, r0 = rd_cnt;
    host_val = 32'hA5A50F0F;
    shift_frame({1'b1, 7'h2A, 32'h0}, 40, cap);
    checks++;
    if (rd_cnt - r0 !== 1 || last_rd_addr !== 7'h2A) begin
      errors++; $display("FAIL read_req: got %0d reqs addr=%h expected 1 addr=2a", rd_cnt - r0, last_rd_addr);
    end
    checks++;
    if (cap !== 32'hA5A50F0F) begin
      errors++; $display("FAIL read_data: got %h expected a5a50f0f", cap);
    end
    checks++;
    if (wr_cnt - w0 !== 0) begin
      errors++; $display("FAIL read_no_write: got %0d writes expected 0", wr_cnt - w0);
    end
  endtask

  task automatic test_abort;
    logic [31:0] cap;
    int w0 = wr_cnt, e0 = err_cnt;
    shift_frame({1'b0, 7'h44, 32'hCAFEF00D}, 17, cap);
    checks++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 0) begin
      errors++; $display("FAIL abort_17: got err=%0d wr=%0d expected 1/0", err_cnt - e0, wr_cnt - w0);
    end
    shift_frame({1'b0, 7'h01, 32'h00000001}, 40, cap);
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_addr !== 7'h01 || last_wr_data !== 32'h1 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL after_abort_write: got %0d writes %h/%h expected 1 01/00000001", wr_cnt - w0, last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_overclock;
    logic [31:0] cap;
    int w0 = wr_cnt, e0 = err_cnt;
    shift_frame({1'b0, 7'h7F, 32'hFFFFFFFF}, 44, cap);
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_addr !== 7'h7F || last_wr_data !== 32'hFFFFFFFF || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL overclock_write: got %0d writes %h/%h err=%0d expected 1 7f/ffffffff err=0",
                         wr_cnt - w0, last_wr_addr, last_wr_data, err_cnt - e0);
    end
    checks++;
    if (bit_count !== 6'd40) begin
      errors++; $display("FAIL overclock_saturate: got %0d expected 40", bit_count);
    end
  endtask

  task automatic test_reset_midframe;
    logic [39:0] f = {1'b0, 7'h55, 32'h89ABCDEF};
    logic [31:0] cap;
    int w0 = wr_cnt, e0 = err_cnt;
    spi_cs_n = 1'b0;
    clk_wait(5);
    for (int i = 1; i <= 40; i++) begin
      if (i == 21) begin
        reset = 1'b1; clk_wait(2);
        checks++;
        if (bit_count !== 6'd0 || wr_valid !== 1'b0 || miso_oe !== 1'b0) begin
          errors++; $display("FAIL midframe_reset_clear: got bc=%0d wv=%b oe=%b expected 0/0/0", bit_count, wr_valid, miso_oe);
        end
        reset = 1'b0; clk_wait(2);
      end
      spi_mosi = f[40 - i];
      clk_wait(5); spi_sclk = 1'b1;
      clk_wait(5); spi_sclk = 1'b0;
    end
    clk_wait(5); spi_cs_n = 1'b1; clk_wait(12);
    checks++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL midframe_ignored: got wr=%0d err=%0d expected 0/0", wr_cnt - w0, err_cnt - e0);
    end
    shift_frame({1'b0, 7'h03, 32'h12345678}, 40, cap);
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_addr !== 7'h03 || last_wr_data !== 32'h12345678) begin
      errors++; $display("FAIL after_reset_write: got %0d writes %h/%h expected 1 03/12345678", wr_cnt - w0, last_wr_addr, last_wr_data);
    end
  endtask

  // Model: n = min(edges, 40). Full frame -> write or read; 1..39 -> frame_err; read req once 8 bits seen.
  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      logic        rw = 1'($urandom_range(0, 1));
      logic [6:0]  a  = 7'($urandom);
      logic [31:0] d  = $urandom;
      logic [31:0] cap;
      int edges = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 39)) : 40 + int'($urandom_range(0, 3));
      int n = (edges > 40) ? 40 : edges;
      int w0 = wr_cnt, e0 = err_cnt, r0 = rd_cnt, m0 = miso_hi_cnt;
      int exp_wr = (n == 40 && !rw) ? 1 : 0;
      int exp_err = (n < 40) ? 1 : 0;
      int exp_rd = (n >= 8 && rw) ? 1 : 0;
      host_val = d;
      shift_frame({rw, a, rw ? 32'($urandom) : d}, edges, cap);
      checks++;
      if (wr_cnt - w0 !== exp_wr || err_cnt - e0 !== exp_err || rd_cnt - r0 !== exp_rd) begin
        errors++; $display("FAIL rand_events[%0d]: got wr=%0d err=%0d rd=%0d expected %0d/%0d/%0d (rw=%b edges=%0d)",
                           it, wr_cnt - w0, err_cnt - e0, rd_cnt - r0, exp_wr, exp_err, exp_rd, rw, edges);
      end
      if (exp_wr == 1) begin
        checks++;
        if (last_wr_addr !== a || last_wr_data !== d) begin
          errors++; $display("FAIL rand_write[%0d]: got %h/%h expected %h/%h", it, last_wr_addr, last_wr_data, a, d);
        end
      end
      if (exp_rd == 1) begin
        checks++;
        if (last_rd_addr !== a) begin
          errors++; $display("FAIL rand_rd_addr[%0d]: got %h expected %h", it, last_rd_addr, a);
        end
      end
      if (rw && n == 40) begin
        checks++;
        if (cap !== d) begin
          errors++; $display("FAIL rand_read_data[%0d]: got %h expected %h", it, cap, d);
        end
      end
      if (!rw) begin
        checks++;
        if (miso_hi_cnt - m0 !== 0) begin
          errors++; $display("FAIL rand_miso_quiet[%0d]: got %0d high samples expected 0", it, miso_hi_cnt - m0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_toggles();
    test_write();
    test_read();
    test_abort();
    test_overclock();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
